// File: rtl/unit_bus_arbiter_pkg.sv
// Shared unit codes, enable constants and arbiter types for the unit transfer bus.
package unit_bus_arbiter_pkg;

    localparam int UNIT_CODE_W = 4;
    localparam int UNIT_CNT    = 16;

    typedef logic [UNIT_CODE_W-1:0] unit_code_t;
    typedef logic [UNIT_CNT-1:0]    unit_en_t;

    localparam unit_code_t REG_NULL = 4'h0;
    localparam unit_code_t MEM_NULL = 4'hF;

    localparam unit_en_t EN_NULL     = 16'h0001;
    localparam unit_en_t EN_MEM_NULL = 16'h8000;

    typedef enum logic { ARB_OPEN = 1'b0, ARB_LOCK = 1'b1 } arb_state_e;
    typedef enum logic { ID_CORE  = 1'b0, ID_IOSC  = 1'b1 } req_id_e;

    typedef struct packed {
        unit_code_t src;
        unit_code_t tgt;
        logic       lock;
    } xfer_t;

    function automatic req_id_e other_id(req_id_e id);
        return (id == ID_CORE) ? ID_IOSC : ID_CORE;
    endfunction

endpackage

// File: rtl/unit_onehot_dec.sv
// 4-to-16 one-hot decode of a unit code; code 0 selects the NULL unit (bit 0).
module unit_onehot_dec
    import unit_bus_arbiter_pkg::*;
(
    input  unit_code_t code,
    output unit_en_t   onehot
);

    always_comb onehot = EN_NULL << code;

endmodule

// File: rtl/unit_bus_arbiter.sv
// Round-robin arbiter with bounded lock ownership sharing the unit bus between core and iosc.
module unit_bus_arbiter
    import unit_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_core_req,
    input  logic [3:0]  i_core_src,
    input  logic [3:0]  i_core_tgt,
    input  logic        i_core_lock,
    output logic        o_core_gnt,
    input  logic        i_iosc_req,
    input  logic [3:0]  i_iosc_src,
    input  logic [3:0]  i_iosc_tgt,
    input  logic        i_iosc_lock,
    output logic        o_iosc_gnt,
    input  logic        i_halt,
    output logic [15:0] o_unit_oen,
    output logic [15:0] o_unit_ien,
    output logic        o_xfer_vld,
    output logic        o_xfer_id,
    output logic        o_locked,
    output logic        o_err
);

    arb_state_e       state_q, state_d;
    req_id_e          ptr_q, ptr_d, owner_q, owner_d, win_id, id_q;
    logic [CNT_W-1:0] hold_q, hold_d;
    xfer_t            core_x, iosc_x, win_x;
    logic             accept, illegal;
    unit_code_t       src_q, tgt_q;
    logic             vld_q, err_q;

    assign core_x = '{src: i_core_src, tgt: i_core_tgt, lock: i_core_lock};
    assign iosc_x = '{src: i_iosc_src, tgt: i_iosc_tgt, lock: i_iosc_lock};

    // Grants are combinational; rst_n gating keeps them low throughout reset.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
        o_core_gnt = 1'b0;
        o_iosc_gnt = 1'b0;
        if (rst_n && !i_halt) begin
            if (state_q == ARB_LOCK) begin
                o_core_gnt = i_core_req && (owner_q == ID_CORE);
                o_iosc_gnt = i_iosc_req && (owner_q == ID_IOSC);
            end else if (i_core_req && i_iosc_req) begin
                o_core_gnt = (ptr_q == ID_CORE);
                o_iosc_gnt = (ptr_q == ID_IOSC);
            end else begin
                o_core_gnt = i_core_req;
                o_iosc_gnt = i_iosc_req;
            end
        end
    end

    assign accept  = o_core_gnt || o_iosc_gnt;
    assign win_id  = o_iosc_gnt ? ID_IOSC : ID_CORE;
    assign win_x   = o_iosc_gnt ? iosc_x : core_x;
    assign illegal = (win_x.src == win_x.tgt) && (win_x.src != REG_NULL);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        if (!i_halt) begin
            if (state_q == ARB_OPEN) begin
                if (accept) begin
                    if (i_core_req && i_iosc_req) ptr_d = other_id(win_id);
                    if (win_x.lock) begin
                        state_d = ARB_LOCK;
                        owner_d = win_id;
                        hold_d  = CNT_W'(1);
                    end
                end
            end else if ((accept && !win_x.lock) || (hold_q == CNT_W'(MAX_HOLD))) begin
                // Release, voluntary or forced, always hands priority to the other requester.
                state_d = ARB_OPEN;
                ptr_d   = other_id(owner_q);
                hold_d  = '0;
            end else begin
                hold_d = hold_q + CNT_W'(1);
            end
        end
    end

    // NOTE: asynchronous active-low reset sits in the sensitivity list of every state flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_OPEN;
            ptr_q   <= ID_CORE;
            owner_q <= ID_CORE;
            hold_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    // Illegal transfers are consumed but never reach the bus; a NULL code pair idles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= REG_NULL;
            tgt_q <= REG_NULL;
            vld_q <= 1'b0;
            id_q  <= ID_CORE;
            err_q <= 1'b0;
        end else if (accept && !illegal) begin
            src_q <= win_x.src;
            tgt_q <= win_x.tgt;
            vld_q <= 1'b1;
            id_q  <= win_id;
        end else begin
            src_q <= REG_NULL;
            tgt_q <= REG_NULL;
            vld_q <= 1'b0;
            if (accept) err_q <= 1'b1;
        end
    end

    unit_onehot_dec u_oen_dec (.code(src_q), .onehot(o_unit_oen));
    unit_onehot_dec u_ien_dec (.code(tgt_q), .onehot(o_unit_ien));

    assign o_xfer_vld = vld_q;
    assign o_xfer_id  = id_q;
    assign o_locked   = (state_q == ARB_LOCK);
    assign o_err      = err_q;

endmodule

// File: tb/tb_unit_bus_arbiter.sv
// Self-checking bench for unit_bus_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_unit_bus_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_lock, iosc_req, iosc_lock, halt;
    logic [3:0]  core_src, core_tgt, iosc_src, iosc_tgt;
    logic        core_gnt, iosc_gnt, xfer_vld, xfer_id, locked, err;
    logic [15:0] unit_oen, unit_ien;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state: plain integers, no RTL encodings.
    int          m_locked, m_owner, m_ptr, m_hold;
    logic        m_err;
    logic [15:0] e_oen, e_ien;
    logic        e_vld, e_id, e_gc, e_gi;
    logic        o_gc, o_gi, o_pre_locked;

    always #5 clk = ~clk;

    unit_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_core_req(core_req), .i_core_src(core_src), .i_core_tgt(core_tgt),
        .i_core_lock(core_lock), .o_core_gnt(core_gnt),
        .i_iosc_req(iosc_req), .i_iosc_src(iosc_src), .i_iosc_tgt(iosc_tgt),
        .i_iosc_lock(iosc_lock), .o_iosc_gnt(iosc_gnt),
        .i_halt(halt), .o_unit_oen(unit_oen), .o_unit_ien(unit_ien),
        .o_xfer_vld(xfer_vld), .o_xfer_id(xfer_id), .o_locked(locked), .o_err(err)
    );

    function automatic void model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_err = 1'b0;
        e_oen = 16'h0001; e_ien = 16'h0001; e_vld = 1'b0; e_id = 1'b0;
        e_gc = 1'b0; e_gi = 1'b0;
    endfunction

    function automatic void model_grant();
        e_gc = 1'b0;
        e_gi = 1'b0;
        if (rst_n && !halt) begin
            if (m_locked != 0) begin
                e_gc = core_req && (m_owner == 0);
                e_gi = iosc_req && (m_owner == 1);
            end else if (core_req && iosc_req) begin
                e_gc = (m_ptr == 0);
                e_gi = (m_ptr == 1);
            end else begin
                e_gc = core_req;
                e_gi = iosc_req;
            end
        end
    endfunction

    function automatic void model_edge();
        int w;
        logic [3:0] s, t;
        logic lk;
        w  = e_gc ? 0 : (e_gi ? 1 : -1);
        s  = (w == 1) ? iosc_src  : core_src;
        t  = (w == 1) ? iosc_tgt  : core_tgt;
        lk = (w == 1) ? iosc_lock : core_lock;
        e_vld = 1'b0; e_oen = 16'h0001; e_ien = 16'h0001;
        if (w >= 0) begin
            if (s == t && s != 4'h0) m_err = 1'b1;
            else begin
                e_vld = 1'b1; e_id = (w == 1);
                e_oen = 16'h0001 << s; e_ien = 16'h0001 << t;
            end
        end
        if (!halt) begin
            if (m_locked != 0) begin
                if ((w == m_owner && !lk) || m_hold == MAX_HOLD) begin
                    m_locked = 0; m_ptr = 1 - m_owner;
                end else m_hold++;
            end else if (w >= 0) begin
                if (core_req && iosc_req) m_ptr = 1 - w;
                if (lk) begin m_locked = 1; m_owner = w; m_hold = 1; end
            end
        end
    endfunction

    // One clock: sample combinational outputs mid-cycle, advance model at the edge, settle 1 ns.
    task automatic tick();
        #3;
        model_grant();
        o_gc = core_gnt; o_gi = iosc_gnt; o_pre_locked = locked;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0;
        core_req = 1'b1; core_src = 4'h1; core_tgt = 4'h2; core_lock = 1'b0;
        iosc_req = 1'b1; iosc_src = 4'h3; iosc_tgt = 4'h4; iosc_lock = 1'b0;
        #12;
        n_checks++; if ({core_gnt, iosc_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {core_gnt, iosc_gnt}); else n_pass++;
        n_checks++; if (unit_oen !== 16'h0001) $display("FAIL reset_oen: got %h want 0001", unit_oen); else n_pass++;
        n_checks++; if (unit_ien !== 16'h0001) $display("FAIL reset_ien: got %h want 0001", unit_ien); else n_pass++;
        n_checks++; if ({xfer_vld, xfer_id, locked, err} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {xfer_vld, xfer_id, locked, err}); else n_pass++;
        core_req = 1'b0; iosc_req = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        core_req = 1'b1; core_src = 4'h4; core_tgt = 4'h8; core_lock = 1'b0;
        tick();
        n_checks++; if ({o_gc, o_gi} !== 2'b10) $display("FAIL single_gnt: got %b want 10", {o_gc, o_gi}); else n_pass++;
        n_checks++; if ({unit_oen, unit_ien} !== {16'h0010, 16'h0100}) $display("FAIL single_en: got %h/%h want 0010/0100", unit_oen, unit_ien); else n_pass++;
        n_checks++; if ({xfer_vld, xfer_id} !== 2'b10) $display("FAIL single_vld_id: got %b want 10", {xfer_vld, xfer_id}); else n_pass++;
        core_req = 1'b0;
        tick();
        n_checks++; if ({unit_oen, unit_ien, xfer_vld} !== {16'h0001, 16'h0001, 1'b0}) $display("FAIL single_idle: got %h/%h vld %b want 0001/0001 vld 0", unit_oen, unit_ien, xfer_vld); else n_pass++;
    endtask

    task automatic test_alternate();
        logic prev_id;
        core_req = 1'b1; core_src = 4'h1; core_tgt = 4'h2; core_lock = 1'b0;
        iosc_req = 1'b1; iosc_src = 4'h3; iosc_tgt = 4'h4; iosc_lock = 1'b0;
        prev_id = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if ({o_gc, o_gi} !== {e_gc, e_gi}) $display("FAIL alt_gnt[%0d]: got %b want %b", i, {o_gc, o_gi}, {e_gc, e_gi}); else n_pass++;
            n_checks++; if ({xfer_vld, xfer_id, unit_oen, unit_ien} !== {1'b1, e_id, e_oen, e_ien}) $display("FAIL alt_bus[%0d]: got vld %b id %b %h/%h want vld 1 id %b %h/%h", i, xfer_vld, xfer_id, unit_oen, unit_ien, e_id, e_oen, e_ien); else n_pass++;
            if (i > 0) begin
                n_checks++; if (xfer_id === prev_id) $display("FAIL alt_toggle[%0d]: got id %b want %b", i, xfer_id, ~prev_id); else n_pass++;
            end
            prev_id = xfer_id;
        end
        core_req = 1'b0; iosc_req = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        int cnt;
        bit released;
        iosc_req = 1'b1; iosc_src = 4'h9; iosc_tgt = 4'hA; iosc_lock = 1'b1;
        tick();
        n_checks++; if ({o_gi, locked} !== 2'b11) $display("FAIL lock_enter: got gnt %b locked %b want 1 1", o_gi, locked); else n_pass++;
        iosc_req = 1'b0;
        core_req = 1'b1; core_src = 4'h3; core_tgt = 4'h4; core_lock = 1'b0;
        cnt = 0; released = 0;
        for (int i = 0; i < 20 && !released; i++) begin
            tick();
            if (o_pre_locked) begin
                cnt++;
                n_checks++; if (o_gc !== 1'b0) $display("FAIL lock_core_blocked[%0d]: got %b want 0", i, o_gc); else n_pass++;
            end else begin
                released = 1;
                n_checks++; if (o_gc !== 1'b1) $display("FAIL lock_handover: got %b want 1", o_gc); else n_pass++;
                n_checks++; if ({unit_oen, unit_ien, xfer_id} !== {16'h0008, 16'h0010, 1'b0}) $display("FAIL lock_handover_bus: got %h/%h id %b want 0008/0010 id 0", unit_oen, unit_ien, xfer_id); else n_pass++;
            end
        end
        n_checks++; if (!released || cnt != MAX_HOLD) $display("FAIL lock_hold_len: got %0d locked cycles (released %0d) want %0d", cnt, released, MAX_HOLD); else n_pass++;
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        core_req = 1'b1; core_src = 4'h5; core_tgt = 4'h5; core_lock = 1'b0;
        tick();
        n_checks++; if (o_gc !== 1'b1) $display("FAIL illegal_gnt: got %b want 1", o_gc); else n_pass++;
        n_checks++; if ({unit_oen, unit_ien, xfer_vld, err} !== {16'h0001, 16'h0001, 1'b0, 1'b1}) $display("FAIL illegal_bus: got %h/%h vld %b err %b want 0001/0001 vld 0 err 1", unit_oen, unit_ien, xfer_vld, err); else n_pass++;
        core_req = 1'b0;
        tick();
        n_checks++; if (err !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", err); else n_pass++;
        core_req = 1'b1; core_src = 4'h2; core_tgt = 4'h3;
        tick();
        n_checks++; if ({unit_oen, unit_ien, xfer_vld, err} !== {16'h0004, 16'h0008, 1'b1, 1'b1}) $display("FAIL illegal_recover: got %h/%h vld %b err %b want 0004/0008 vld 1 err 1", unit_oen, unit_ien, xfer_vld, err); else n_pass++;
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        int cnt;
        bit released;
        core_req = 1'b1; core_src = 4'h1; core_tgt = 4'h2; core_lock = 1'b1;
        tick();
        n_checks++; if ({o_gc, locked} !== 2'b11) $display("FAIL halt_lock_enter: got gnt %b locked %b want 1 1", o_gc, locked); else n_pass++;
        cnt = 0;
        core_req = 1'b0;
        tick(); if (o_pre_locked) cnt++;
        core_req = 1'b1; core_src = 4'h3; core_tgt = 4'h4;
        tick(); if (o_pre_locked) cnt++;
        halt = 1'b1; core_src = 4'h6; core_tgt = 4'h7;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({o_gc, o_gi} !== 2'b00) $display("FAIL halt_gnt[%0d]: got %b want 00", i, {o_gc, o_gi}); else n_pass++;
            n_checks++; if ({unit_oen, xfer_vld, locked} !== {16'h0001, 1'b0, 1'b1}) $display("FAIL halt_bus[%0d]: got %h vld %b locked %b want 0001 vld 0 locked 1", i, unit_oen, xfer_vld, locked); else n_pass++;
        end
        halt = 1'b0;
        tick(); if (o_pre_locked) cnt++;
        n_checks++; if (o_gc !== 1'b1) $display("FAIL halt_resume_gnt: got %b want 1", o_gc); else n_pass++;
        n_checks++; if ({unit_oen, unit_ien} !== {16'h0040, 16'h0080}) $display("FAIL halt_resume_bus: got %h/%h want 0040/0080", unit_oen, unit_ien); else n_pass++;
        core_req = 1'b0; core_lock = 1'b0;
        released = 0;
        for (int i = 0; i < 20 && !released; i++) begin
            tick();
            if (o_pre_locked) cnt++; else released = 1;
        end
        n_checks++; if (!released || cnt != MAX_HOLD) $display("FAIL halt_hold_frozen: got %0d running locked cycles (released %0d) want %0d", cnt, released, MAX_HOLD); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if (!core_req || e_gc) begin
                core_req  = ($urandom_range(0, 3) != 0);
                core_src  = 4'($urandom);
                core_tgt  = ($urandom_range(0, 9) == 0) ? core_src : 4'($urandom);
                core_lock = ($urandom_range(0, 7) == 0);
            end
            if (!iosc_req || e_gi) begin
                iosc_req  = ($urandom_range(0, 3) != 0);
                iosc_src  = 4'($urandom);
                iosc_tgt  = ($urandom_range(0, 9) == 0) ? iosc_src : 4'($urandom);
                iosc_lock = ($urandom_range(0, 7) == 0);
            end
            halt = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++; if ({o_gc, o_gi} !== {e_gc, e_gi}) $display("FAIL rand_gnt[%0d]: got %b want %b", i, {o_gc, o_gi}, {e_gc, e_gi}); else n_pass++;
            n_checks++; if ({unit_oen, unit_ien, xfer_vld, locked, err} !== {e_oen, e_ien, e_vld, (m_locked != 0), m_err})
                $display("FAIL rand_bus[%0d]: got %h/%h vld %b lk %b err %b want %h/%h vld %b lk %b err %b", i, unit_oen, unit_ien, xfer_vld, locked, err, e_oen, e_ien, e_vld, (m_locked != 0), m_err);
            else n_pass++;
            if (e_vld) begin
                n_checks++; if (xfer_id !== e_id) $display("FAIL rand_id[%0d]: got %b want %b", i, xfer_id, e_id); else n_pass++;
            end
        end
        halt = 1'b0; core_req = 1'b0; iosc_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit granted;
        core_req = 1'b1; core_src = 4'h1; core_tgt = 4'h2; core_lock = 1'b1;
        granted = 0;
        for (int i = 0; i < 20 && !granted; i++) begin
            tick();
            granted = o_gc;
        end
        n_checks++; if (!granted || xfer_vld !== 1'b1) $display("FAIL rstmid_accept: got gnt %0d vld %b want 1 1", granted, xfer_vld); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({unit_oen, unit_ien} !== {16'h0001, 16'h0001}) $display("FAIL rstmid_en: got %h/%h want 0001/0001", unit_oen, unit_ien); else n_pass++;
        n_checks++; if ({xfer_vld, locked, err, core_gnt} !== 4'b0000) $display("FAIL rstmid_flags: got %b want 0000", {xfer_vld, locked, err, core_gnt}); else n_pass++;
        core_req = 1'b0; core_lock = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        core_req = 1'b1; iosc_req = 1'b1; iosc_lock = 1'b0;
        iosc_src = 4'h3; iosc_tgt = 4'h4;
        tick();
        n_checks++; if ({o_gc, o_gi} !== 2'b10) $display("FAIL rstmid_ptr: got %b want 10", {o_gc, o_gi}); else n_pass++;
        core_req = 1'b0; iosc_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_illegal();
        test_halt();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unit_bus_arbiter.md
Name: unit_bus_arbiter

Overview:
- Shares the core unit transfer bus (one-hot source/target enables) between two requesters: the core instruction decoder (core) and the IO sub-controller (iosc).
- Arbitrates with a round-robin pointer and supports lock/burst ownership bounded by a hold limit.
- Registers the winning transfer and drives it onto the unit enable bus one cycle after acceptance.
- Sits between both requesters and the register/ALU/memory units.

Parameters:
- MAX_HOLD, 8: maximum cycles a requester may keep the bus locked.
- CNT_W, 4: hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_core_req  input  1  core transfer request.
- i_core_src  input  4  core source unit code.
- i_core_tgt  input  4  core target unit code.
- i_core_lock  input  1  core requests to keep the bus after this transfer.
- o_core_gnt  output  1  core transfer accepted this cycle.
- i_iosc_req  input  1  iosc transfer request.
- i_iosc_src  input  4  iosc source unit code.
- i_iosc_tgt  input  4  iosc target unit code.
- i_iosc_lock  input  1  iosc lock request.
- o_iosc_gnt  output  1  iosc transfer accepted this cycle.
- i_halt  input  1  freeze arbitration.
- o_unit_oen  output  16  one-hot source enable; bit n = unit code n.
- o_unit_ien  output  16  one-hot target enable.
- o_xfer_vld  output  1  a transfer is on the bus this cycle.
- o_xfer_id  output  1  owner of the current bus transfer: 0 = core, 1 = iosc.
- o_locked  output  1  the bus is in the LOCK state.
- o_err  output  1  sticky illegal-transfer flag.

Behaviour:
- Reset (async, rst_n low):
  - o_unit_oen = o_unit_ien = 16'h0001 (NULL unit).
  - o_xfer_vld = 0, o_xfer_id = 0, o_locked = 0, o_err = 0.
  - Round-robin pointer = 0 (core), state = OPEN, hold_cnt = 0.
  - gnt outputs are forced to 0 while rst_n is low.
- Handshake is valid/ready:
  - gnt is combinational from req, state, pointer and i_halt.
  - A transfer is accepted when req & gnt at the rising edge.
  - The requester holds src/tgt stable while req=1 and gnt=0, and may present its next transfer in the cycle after gnt.
- Latency: accepted at edge N, enables driven during cycle N+1 for exactly one cycle.
  - Back-to-back accepts give one transfer per cycle.
  - A cycle with no accept drives NULL enables and o_xfer_vld = 0.
- State OPEN:
  - If only one requester has req=1, it is granted.
  - If both have req=1, the pointer's requester is granted and the pointer flips to the other requester after the accept.
  - If the accepted transfer has lock=1: go to LOCK, owner = winner, hold_cnt = 1.
- State LOCK:
  - Only the owner can be granted; the other requester's gnt = 0.
  - hold_cnt increments every non-halted cycle, whether or not the owner accepts.
  - Exit to OPEN when the owner's transfer is accepted with lock=0.
  - Exit to OPEN when hold_cnt reaches MAX_HOLD (forced release). That cycle's owner accept, if any, still completes.
  - On exit, the pointer is set to the non-owner. o_locked = 1 exactly while in LOCK.
- Transfer legality:
  - src == tgt with the code non-zero: accepted (gnt asserted), but the enables stay NULL, o_xfer_vld = 0, and o_err sets.
  - o_err clears only on reset.
  - src = tgt = 0 is a legal no-op: o_xfer_vld = 1 with NULL enables.
- i_halt = 1:
  - All gnt = 0, and the next cycle drives NULL enables.
  - State, pointer and hold_cnt are frozen.
  - Deasserting i_halt resumes arbitration in the same cycle.
- Simultaneous events: a forced release coinciding with the non-owner's req hands the bus to the non-owner at the next edge (OPEN, pointer = non-owner).
- Reset mid-transfer: the registered transfer is discarded and the bus returns to NULL immediately (asynchronously).

Decomposition:
- Shared define/package holds:
  - 4-bit unit codes (REG_NULL=0 … MEM_NULL=15).
  - 16-bit one-hot enable constants.
  - Arbiter state encodings (OPEN, LOCK).
  - Requester ids.
- Sub-module: unit_onehot_dec, a 4-to-16 one-hot decode with code 0 → 16'h0001, parameter-free.
  - Instantiated twice, for oen and ien.
  - Reusable by the instruction decoder.

Test Plan:
- Reset, then core req src=4'h4 tgt=4'h8, no lock → core gnt in cycle 0; cycle 1 oen=16'h0010, ien=16'h0100, vld=1, id=0; the bus then returns to 16'h0001.
- Both requesters request continuously, no lock → grants alternate core, iosc, core, …; o_xfer_id alternates 0,1,0 with one transfer per cycle.
- iosc accepted with lock=1 and core req held, MAX_HOLD=8 → o_locked=1 for 8 cycles, core gnt=0 throughout; forced release, core granted next.
- Core src=tgt=4'h5 → gnt=1; next cycle NULL enables, vld=0, o_err=1 and it stays 1; a subsequent legal transfer still completes.
- i_halt=1 for 3 cycles with a request pending → no gnt, NULL enables, hold_cnt frozen mid-lock; after halt drops, the pending transfer is granted the same cycle.
- rst_n asserted the cycle after an accept → enables go to 16'h0001 immediately, o_locked=0, pointer=core.
